// File: rtl/GEMM_pkg.sv
// GEMM_pkg: shared state encoding and array latency helper for the GEMM tile sequencer.
package GEMM_pkg;
   typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD_W, SEQ_STREAM, SEQ_DRAIN} seq_state_t;
   function automatic int sa_latency(input int sa_size);
      return 2 * sa_size;
   endfunction
endpackage

// File: rtl/gemm_seq_valid_pipe.sv
// gemm_seq_valid_pipe: DEPTH-stage shift register of 1-bit valid tags shadowing the stall-free array.
module gemm_seq_valid_pipe #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic tag_in,
   output logic tag_out,
   output logic empty
);
   logic [DEPTH-1:0] tags;
   always_ff @(posedge clk)
      if (!resetn) tags <= '0;
      else tags <= {tags[DEPTH-2:0], tag_in};
   assign tag_out = tags[DEPTH-1];
   assign empty = ~|tags;
endmodule

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: loads weights into one systolic tile, streams activations, tags results, signals job completion.
// Optional GEMM_SEQ_PERF_CNT_EN adds bubble and job-cycle performance counters.
module gemm_tile_sequencer
   import GEMM_pkg::*;
#(
   parameter int SA_SIZE = 3,
   parameter int WEIGHT_ACTIVATION_SIZE = 8,
   parameter int VEC_CNT_W = 16
) (
   input  logic clk,
   input  logic resetn,
   input  logic cmd_valid,
   output logic cmd_ready,
   input  logic [VEC_CNT_W-1:0] cmd_num_vectors,
   input  logic w_valid,
   output logic w_ready,
   input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] w_row,
   input  logic a_valid,
   output logic a_ready,
   input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] a_vec,
   output logic sa_weight_we,
   output logic [$clog2(SA_SIZE)-1:0] sa_weight_row_idx,
   output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] sa_weight_row,
   output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] sa_act_in,
   input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] sa_act_out,
   output logic res_valid,
   output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] res_vec,
   output logic job_done,
   output logic busy
`ifdef GEMM_SEQ_PERF_CNT_EN
   ,
   output logic [31:0] perf_bubble_cnt,
   output logic [31:0] perf_job_cycles
`endif
);
   localparam int LAT = sa_latency(SA_SIZE);
   localparam int RW = $clog2(SA_SIZE);
   seq_state_t state, state_nx;
   logic [VEC_CNT_W-1:0] num_vectors, issued;
   logic [RW-1:0] row_idx;
   logic cmd_fire, w_fire, a_fire, last_row, last_vec, tag_out, pipe_empty;
   assign cmd_ready = state == SEQ_IDLE;
   assign w_ready = state == SEQ_LOAD_W;
   assign a_ready = state == SEQ_STREAM && issued != num_vectors;
   assign busy = state != SEQ_IDLE;
   assign cmd_fire = cmd_valid && cmd_ready;
   assign w_fire = w_valid && w_ready;
   assign a_fire = a_valid && a_ready;
   assign last_row = row_idx == RW'(SA_SIZE - 1);
   assign last_vec = issued + VEC_CNT_W'(1) == num_vectors;
   // Completion waits one cycle past the final result so the consumer sees it before job_done.
   assign job_done = state == SEQ_DRAIN && pipe_empty && !res_valid;
   assign sa_weight_we = w_fire;
   assign sa_weight_row_idx = row_idx;
   assign sa_weight_row = w_fire ? w_row : '0;
   assign sa_act_in = a_fire ? a_vec : '0;
   always_comb begin
      state_nx = state;
      case (state)
         SEQ_IDLE:   state_nx = cmd_fire ? SEQ_LOAD_W : SEQ_IDLE;
         SEQ_LOAD_W: state_nx = !(w_fire && last_row) ? SEQ_LOAD_W : num_vectors == '0 ? SEQ_DRAIN : SEQ_STREAM;
         SEQ_STREAM: state_nx = a_fire && last_vec ? SEQ_DRAIN : SEQ_STREAM;
         SEQ_DRAIN:  state_nx = job_done ? SEQ_IDLE : SEQ_DRAIN;
         default:    state_nx = SEQ_IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (!resetn) begin
         state <= SEQ_IDLE;
         num_vectors <= '0;
         issued <= '0;
         row_idx <= '0;
         res_valid <= 1'b0;
         res_vec <= '0;
      end else begin
         state <= state_nx;
         if (cmd_fire) begin
            num_vectors <= cmd_num_vectors;
            issued <= '0;
            row_idx <= '0;
         end
         if (w_fire) row_idx <= row_idx + RW'(1);
         if (a_fire) issued <= issued + VEC_CNT_W'(1);
         res_valid <= tag_out;
         if (tag_out) res_vec <= sa_act_out;
      end
   gemm_seq_valid_pipe #(.DEPTH(LAT)) u_valid_pipe (
      .clk(clk),
      .resetn(resetn),
      .tag_in(a_fire),
      .tag_out(tag_out),
      .empty(pipe_empty)
   );
`ifdef GEMM_SEQ_PERF_CNT_EN
   always_ff @(posedge clk)
      if (!resetn || cmd_fire) begin
         perf_bubble_cnt <= '0;
         perf_job_cycles <= '0;
      end else begin
         if (busy) perf_job_cycles <= perf_job_cycles + {31'd0, perf_job_cycles != '1};
         if (state == SEQ_STREAM && !a_fire) perf_bubble_cnt <= perf_bubble_cnt + {31'd0, perf_bubble_cnt != '1};
      end
`endif
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb_gemm_tile_sequencer: directed scenarios against a behavioural 2x2 array model with hand-computed results.
module tb_gemm_tile_sequencer;
   logic clk = 1'b0, resetn = 1'b0;
   logic cmd_valid = 1'b0, w_valid = 1'b0, a_valid = 1'b0;
   logic [15:0] cmd_num_vectors = '0, w_row = '0, a_vec = '0;
   logic cmd_ready, w_ready, a_ready, sa_weight_we, res_valid, job_done, busy;
   logic [0:0] sa_weight_row_idx;
   logic [15:0] sa_weight_row, sa_act_in, sa_act_out, res_vec;
`ifdef GEMM_SEQ_PERF_CNT_EN
   logic [31:0] perf_bubble_cnt, perf_job_cycles;
`endif
   int checks = 0, errors = 0, cyc = 0;
   int iss_q[$], rc_q[$], done_q[$], we_q[$], cmd_q[$];
   logic [15:0] rv_q[$];
   logic [15:0] wm [2];
   logic [15:0] dl [4];

   gemm_tile_sequencer #(.SA_SIZE(2), .WEIGHT_ACTIVATION_SIZE(8), .VEC_CNT_W(16)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_vectors(cmd_num_vectors),
      .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
      .a_valid(a_valid), .a_ready(a_ready), .a_vec(a_vec),
      .sa_weight_we(sa_weight_we), .sa_weight_row_idx(sa_weight_row_idx), .sa_weight_row(sa_weight_row),
      .sa_act_in(sa_act_in), .sa_act_out(sa_act_out),
      .res_valid(res_valid), .res_vec(res_vec), .job_done(job_done), .busy(busy)
`ifdef GEMM_SEQ_PERF_CNT_EN
      , .perf_bubble_cnt(perf_bubble_cnt), .perf_job_cycles(perf_job_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Array stand-in: out[j] = sum_k a[k]*W[k][j] (mod 256), delayed by 4 cycles.
   function automatic logic [15:0] mac(input logic [15:0] a);
      logic [7:0] o0, o1;
      o0 = a[7:0] * wm[0][7:0] + a[15:8] * wm[1][7:0];
      o1 = a[7:0] * wm[0][15:8] + a[15:8] * wm[1][15:8];
      return {o1, o0};
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      dl[0] <= mac(sa_act_in);
      for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
      if (sa_weight_we) wm[sa_weight_row_idx] <= sa_weight_row;
   end
   assign sa_act_out = dl[3];

   always @(negedge clk) begin
      if (a_valid && a_ready) iss_q.push_back(cyc);
      if (res_valid) begin rc_q.push_back(cyc); rv_q.push_back(res_vec); end
      if (job_done) done_q.push_back(cyc);
      if (sa_weight_we) we_q.push_back(cyc);
      if (cmd_valid && cmd_ready) cmd_q.push_back(cyc);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic clear_logs();
      iss_q.delete(); rc_q.delete(); done_q.delete(); we_q.delete(); cmd_q.delete(); rv_q.delete();
   endtask
   task automatic start_job(input int n);
      cmd_valid = 1'b1; cmd_num_vectors = 16'(n);
      tick();
      cmd_valid = 1'b0;
   endtask
   task automatic load_w();
      w_valid = 1'b1; w_row = {8'd0, 8'd3};
      tick();
      w_row = {8'd2, 8'd0};
      tick();
      w_valid = 1'b0;
   endtask
   task automatic send(input logic [15:0] v);
      a_valid = 1'b1; a_vec = v;
      tick();
      a_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      run(2);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if ({res_valid, job_done, w_ready, a_ready, sa_weight_we} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b want 00000", {res_valid, job_done, w_ready, a_ready, sa_weight_we}); end
      checks++; if (res_vec !== 16'h0 || sa_act_in !== 16'h0) begin errors++; $display("FAIL reset_data got %h/%h want 0000/0000", res_vec, sa_act_in); end
`ifdef GEMM_SEQ_PERF_CNT_EN
      checks++; if (perf_bubble_cnt !== 32'd0 || perf_job_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_bubble_cnt, perf_job_cycles); end
`endif
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      clear_logs();
      start_job(1);
      checks++; if ({busy, w_ready, cmd_ready} !== 3'b110) begin errors++; $display("FAIL basic_load_state got %b want 110", {busy, w_ready, cmd_ready}); end
      load_w();
      checks++; if (we_q.size() !== 2 || we_q[1] - we_q[0] !== 1) begin errors++; $display("FAIL basic_we got %0d pulses want 2 consecutive", we_q.size()); end
      a_valid = 1'b1; a_vec = {8'd5, 8'd2};
      #1;
      checks++; if (a_ready !== 1'b1 || sa_act_in !== 16'h0502) begin errors++; $display("FAIL basic_act_in got %b/%h want 1/0502", a_ready, sa_act_in); end
      tick();
      a_valid = 1'b0;
      run(10);
      checks++; if (rc_q.size() !== 1 || rc_q[0] - iss_q[0] !== 5) begin errors++; $display("FAIL basic_latency got n=%0d dt=%0d want n=1 dt=5", rc_q.size(), rc_q[0] - iss_q[0]); end
      checks++; if (rv_q[0] !== {8'd10, 8'd6}) begin errors++; $display("FAIL basic_result got %h want 0a06", rv_q[0]); end
      checks++; if (done_q.size() !== 1 || done_q[0] - iss_q[0] !== 6) begin errors++; $display("FAIL basic_done got n=%0d dt=%0d want n=1 dt=6", done_q.size(), done_q[0] - iss_q[0]); end
      checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_idle got busy=%b ready=%b want 0/1", busy, cmd_ready); end
   endtask

   task automatic test_back_to_back();
      clear_logs();
      start_job(2);
      load_w();
      a_valid = 1'b1; a_vec = {8'd5, 8'd2};
      tick();
      a_vec = {8'd2, 8'd3};
      tick();
      a_valid = 1'b0;
      run(12);
      checks++; if (iss_q.size() !== 2 || iss_q[1] - iss_q[0] !== 1) begin errors++; $display("FAIL b2b_issue got n=%0d want 2 consecutive", iss_q.size()); end
      checks++; if (rc_q.size() !== 2 || rc_q[0] - iss_q[0] !== 5 || rc_q[1] - rc_q[0] !== 1) begin errors++; $display("FAIL b2b_res_timing got n=%0d want 2 consecutive at t+5", rc_q.size()); end
      checks++; if (rv_q[0] !== 16'h0a06 || rv_q[1] !== 16'h0409) begin errors++; $display("FAIL b2b_res_values got %h,%h want 0a06,0409", rv_q[0], rv_q[1]); end
      checks++; if (done_q.size() !== 1 || done_q[0] - iss_q[0] !== 7) begin errors++; $display("FAIL b2b_done got n=%0d dt=%0d want n=1 dt=7", done_q.size(), done_q[0] - iss_q[0]); end
   endtask

   task automatic test_bubbles();
      clear_logs();
      start_job(3);
      load_w();
      send({8'd5, 8'd2});
      run(2);
      send({8'd2, 8'd3});
      send({8'd1, 8'd1});
      run(12);
      checks++; if (iss_q.size() !== 3 || iss_q[1] - iss_q[0] !== 3 || iss_q[2] - iss_q[1] !== 1) begin errors++; $display("FAIL bub_issue got n=%0d want gaps 3,1", iss_q.size()); end
      checks++; if (rc_q.size() !== 3 || rc_q[0] - iss_q[0] !== 5 || rc_q[1] - iss_q[1] !== 5 || rc_q[2] - iss_q[2] !== 5) begin errors++; $display("FAIL bub_res_timing got n=%0d want 3 at t+5", rc_q.size()); end
      checks++; if (rv_q[2] !== {8'd2, 8'd3}) begin errors++; $display("FAIL bub_res_value got %h want 0203", rv_q[2]); end
      checks++; if (done_q.size() !== 1 || done_q[0] - iss_q[2] !== 6) begin errors++; $display("FAIL bub_done got n=%0d want 1 at t+6", done_q.size()); end
`ifdef GEMM_SEQ_PERF_CNT_EN
      checks++; if (perf_bubble_cnt !== 32'd2) begin errors++; $display("FAIL bub_perf_bubbles got %0d want 2", perf_bubble_cnt); end
      checks++; if (perf_job_cycles !== 32'd13) begin errors++; $display("FAIL bub_perf_cycles got %0d want 13", perf_job_cycles); end
`endif
   endtask

   task automatic test_zero_vectors();
      clear_logs();
      start_job(0);
      load_w();
      run(6);
      checks++; if (we_q.size() !== 2) begin errors++; $display("FAIL zero_we got %0d want 2", we_q.size()); end
      checks++; if (done_q.size() !== 1 || done_q[0] - we_q[1] !== 1) begin errors++; $display("FAIL zero_done got n=%0d dt=%0d want n=1 dt=1", done_q.size(), done_q[0] - we_q[1]); end
      checks++; if (rc_q.size() !== 0) begin errors++; $display("FAIL zero_res got %0d want 0", rc_q.size()); end
   endtask

   task automatic test_reset_mid_stream();
      clear_logs();
      start_job(3);
      load_w();
      send({8'd5, 8'd2});
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got busy=%b ready=%b rv=%b want 0/1/0", busy, cmd_ready, res_valid); end
      run(8);
      checks++; if (rc_q.size() !== 0 || done_q.size() !== 0) begin errors++; $display("FAIL rstmid_outputs got res=%0d done=%0d want 0/0", rc_q.size(), done_q.size()); end
   endtask

   task automatic test_cmd_hold();
      clear_logs();
      cmd_valid = 1'b1; cmd_num_vectors = 16'd1;
      tick();
      load_w();
      send({8'd5, 8'd2});
      for (int i = 0; i < 20 && cmd_q.size() < 2; i++) tick();
      cmd_valid = 1'b0;
      checks++; if (cmd_q.size() !== 2 || done_q.size() !== 1 || cmd_q[1] - done_q[0] !== 1) begin errors++; $display("FAIL hold_accept got cmds=%0d dones=%0d want 2/1 with accept one cycle after done", cmd_q.size(), done_q.size()); end
      load_w();
      send({8'd2, 8'd3});
      run(10);
      checks++; if (done_q.size() !== 2 || rc_q.size() !== 2 || rv_q[1] !== 16'h0409) begin errors++; $display("FAIL hold_second_job got dones=%0d res=%0d val=%h want 2/2/0409", done_q.size(), rc_q.size(), rv_q[1]); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_bubbles();
      test_zero_vectors();
      test_reset_mid_stream();
      test_cmd_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
